// File: rtl/shared_mem_arbiter_if.sv
// Requester/memory-side bundle for the shared data-memory arbiter.
// master = requesters and memory mux, slave = the arbiter itself.
interface shared_mem_arbiter_if;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       mem_en;
  logic [2:0] ack;
  logic       busy;

  modport master (
    output req,
    input  gnt, sel, mem_en, ack, busy
  );

  modport slave (
    input  req,
    output gnt, sel, mem_en, ack, busy
  );
endinterface

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter/sequencer for the shared memory port; ack arrives MEM_LAT+1 cycles after an idle req.
// Requesters hold req until ack; one access outstanding, back-to-back ISSUE straight out of RESP.
module shared_mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  shared_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_n;
  logic [1:0]       win_q, win_n;
  logic [1:0]       last_q, last_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       elig;
  logic [2:0]       pick;

  // Returns {found, index}; later iterations overwrite earlier ones, so the
  // loop runs backwards through the round-robin order to let the first one win.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [2:0] res;
    int         idx;
    res = 3'b000;
    for (int k = 3; k >= 1; k--) begin
      idx = (int'(last) + k) % 3;
      if (r[idx]) res = {1'b1, 2'(idx)};
    end
    return res;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      win_q   <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      win_q   <= win_n;
      last_q  <= last_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    win_n   = win_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    elig    = bus.req;
    // The current winner still holds req during its ack cycle.
    if (state_q == RESP) elig = bus.req & ~(3'b001 << win_q);
    pick = rr_pick(elig, last_q);

    case (state_q)
      IDLE: begin
        if (pick[2]) begin
          win_n   = pick[1:0];
          last_n  = pick[1:0];
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        cnt_n   = CNT_W'(MEM_LAT - 1);
        state_n = (MEM_LAT == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_n = RESP;
      end
      RESP: begin
        if (pick[2]) begin
          win_n   = pick[1:0];
          last_n  = pick[1:0];
          state_n = ISSUE;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.gnt    = (state_q != IDLE) ? (3'b001 << win_q) : 3'b000;
  assign bus.sel    = (state_q != IDLE) ? win_q : 2'd0;
  assign bus.mem_en = (state_q == ISSUE);
  assign bus.ack    = (state_q == RESP) ? (3'b001 << win_q) : 3'b000;

endmodule
